// File: rtl/arm_ctrl_pkg.sv
// rtl/arm_ctrl_pkg.sv - shared encodings for the multicycle ARM-subset control unit
package arm_ctrl_pkg;

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXEC_R = 4'd6;
    localparam logic [3:0] S_EXEC_I = 4'd7;
    localparam logic [3:0] S_ALUWB  = 4'd8;
    localparam logic [3:0] S_BRANCH = 4'd9;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_B   = 2'b10;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [1:0] RES_ALUOUT  = 2'b00;
    localparam logic [1:0] RES_MEMDATA = 2'b01;
    localparam logic [1:0] RES_ALU     = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_8   = 2'b00;
    localparam logic [1:0] IMM_12  = 2'b01;
    localparam logic [1:0] IMM_B24 = 2'b10;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_MOV = 4'b1101;

    typedef struct packed {
        logic       ir_write;
        logic       adr_src;
        logic       pc_write;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_control;
        logic [1:0] imm_src;
        logic [1:0] reg_src;
        logic       shift_flag;
    } ctrl_t;

    function automatic logic [1:0] alu_ctl_of(input logic [3:0] cmd);
        case (cmd)
            CMD_SUB, CMD_CMP: return ALU_SUB;
            CMD_AND:          return ALU_AND;
            CMD_ORR:          return ALU_ORR;
            default:          return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/cond_check.sv
// rtl/cond_check.sv - ARM condition-field evaluation against the {N,Z,C,V} flags
module cond_check
    import arm_ctrl_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_ok
);

    logic n, z, c, v;
    assign {n, z, c, v} = flags;

    always_comb begin
        cond_ok = 1'b0;
        case (cond)
            COND_EQ: cond_ok = z;
            COND_NE: cond_ok = ~z;
            COND_CS: cond_ok = c;
            COND_CC: cond_ok = ~c;
            COND_MI: cond_ok = n;
            COND_PL: cond_ok = ~n;
            COND_VS: cond_ok = v;
            COND_VC: cond_ok = ~v;
            COND_HI: cond_ok = c & ~z;
            COND_LS: cond_ok = ~c | z;
            COND_GE: cond_ok = (n == v);
            COND_LT: cond_ok = (n != v);
            COND_GT: cond_ok = ~z & (n == v);
            COND_LE: cond_ok = z | (n != v);
            COND_AL: cond_ok = 1'b1;
            default: cond_ok = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multicycle Moore control FSM with flag register for the ARM-subset core
module mc_controller
    import arm_ctrl_pkg::*;
#(
    parameter logic [3:0] FLAGS_RST = 4'b0000,
    parameter bit         COND_EN   = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] cond,
    input  logic [1:0] op,
    input  logic [5:0] funct,
    input  logic [3:0] rd,
    input  logic [3:0] alu_flags,
    output logic       ir_write,
    output logic       adr_src,
    output logic       pc_write,
    output logic       mem_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_control,
    output logic [1:0] imm_src,
    output logic [1:0] reg_src,
    output logic       shift_flag,
    output logic [3:0] flags
);

    logic [3:0] state, state_next;
    logic       run;
    logic       cc_ok, cond_ok, cond_ok_q;
    logic [3:0] cmd_q;
    logic       sl_q, rd_pc_q;
    logic [3:0] flags_q;
    logic       in_exec, flag_we, logic_op;
    ctrl_t      ctl;

    cond_check u_cond_check (
        .cond    (cond),
        .flags   (flags_q),
        .cond_ok (cc_ok)
    );

    assign cond_ok = COND_EN ? cc_ok : 1'b1;

    // run holds the strobes low from reset until the first clock after release,
    // while the state register already sits in FETCH.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_FETCH;
            run   <= 1'b0;
        end else if (!run) begin
            run   <= 1'b1;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cond_ok_q <= 1'b0;
            cmd_q     <= 4'b0000;
            sl_q      <= 1'b0;
            rd_pc_q   <= 1'b0;
        end else if (run && state == S_DECODE) begin
            cond_ok_q <= cond_ok;
            cmd_q     <= funct[4:1];
            sl_q      <= funct[0];
            rd_pc_q   <= (rd == 4'hF);
        end
    end

    assign in_exec  = (state == S_EXEC_R) || (state == S_EXEC_I);
    assign logic_op = (cmd_q == CMD_AND) || (cmd_q == CMD_ORR) || (cmd_q == CMD_MOV);
    assign flag_we  = run && in_exec && cond_ok_q && (sl_q || cmd_q == CMD_CMP);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flags_q <= FLAGS_RST;
        end else if (flag_we) begin
            flags_q <= logic_op ? {alu_flags[3:2], flags_q[1:0]} : alu_flags;
        end
    end

    always_comb begin
        state_next = S_FETCH;
        case (state)
            S_FETCH:  state_next = S_DECODE;
            S_DECODE: begin
                if (!cond_ok)          state_next = S_FETCH;
                else if (op == OP_MEM) state_next = S_MEMADR;
                else if (op == OP_B)   state_next = S_BRANCH;
                else if (op == OP_DP)  state_next = funct[5] ? S_EXEC_I : S_EXEC_R;
                else                   state_next = S_FETCH;
            end
            S_MEMADR: state_next = sl_q ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_next = S_MEMWB;
            S_EXEC_R, S_EXEC_I: state_next = (cmd_q == CMD_CMP) ? S_FETCH : S_ALUWB;
            default:  state_next = S_FETCH;
        endcase
    end

    always_comb begin
        ctl = '0;
        case (state)
            S_FETCH: begin
                ctl.ir_write    = 1'b1;
                ctl.alu_src_a   = 1'b1;
                ctl.alu_src_b   = SRCB_FOUR;
                ctl.alu_control = ALU_ADD;
                ctl.result_src  = RES_ALU;
                ctl.pc_write    = 1'b1;
            end
            S_DECODE: begin
                ctl.alu_src_a   = 1'b1;
                ctl.alu_src_b   = SRCB_FOUR;
                ctl.alu_control = ALU_ADD;
            end
            S_MEMADR: begin
                ctl.alu_src_b   = SRCB_IMM;
                ctl.imm_src     = IMM_12;
                ctl.alu_control = ALU_ADD;
            end
            S_MEMRD: ctl.adr_src = 1'b1;
            S_MEMWB: begin
                ctl.result_src = RES_MEMDATA;
                ctl.reg_write  = 1'b1;
                ctl.pc_write   = rd_pc_q;
            end
            S_MEMWR: begin
                ctl.adr_src   = 1'b1;
                ctl.mem_write = 1'b1;
                ctl.reg_src   = 2'b10;
            end
            S_EXEC_R, S_EXEC_I: begin
                ctl.alu_src_b   = (state == S_EXEC_I) ? SRCB_IMM : SRCB_RD2;
                ctl.imm_src     = IMM_8;
                ctl.alu_control = alu_ctl_of(cmd_q);
                ctl.shift_flag  = (cmd_q == CMD_MOV);
            end
            S_ALUWB: begin
                ctl.result_src = RES_ALUOUT;
                ctl.reg_write  = 1'b1;
                ctl.pc_write   = rd_pc_q;
            end
            S_BRANCH: begin
                ctl.alu_src_a   = 1'b0;
                ctl.reg_src     = 2'b01;
                ctl.alu_src_b   = SRCB_IMM;
                ctl.imm_src     = IMM_B24;
                ctl.alu_control = ALU_ADD;
                ctl.result_src  = RES_ALU;
                ctl.pc_write    = 1'b1;
            end
            default: ctl = '0;
        endcase
    end

    assign ir_write    = ctl.ir_write  & run;
    assign pc_write    = ctl.pc_write  & run;
    assign mem_write   = ctl.mem_write & run;
    assign reg_write   = ctl.reg_write & run;
    assign adr_src     = ctl.adr_src;
    assign result_src  = ctl.result_src;
    assign alu_src_a   = ctl.alu_src_a;
    assign alu_src_b   = ctl.alu_src_b;
    assign alu_control = ctl.alu_control;
    assign imm_src     = ctl.imm_src;
    assign reg_src     = ctl.reg_src;
    assign shift_flag  = ctl.shift_flag;
    assign flags       = flags_q;

endmodule
